// File: rtl/con_unit.sv
// Registered, handshaked branch-condition evaluator with saturating statistics.
// Operands are captured on strobe; the decision is held until acknowledged.
module con_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int IR_WIDTH    = 32,
   parameter int COND_LSB    = 19,
   parameter int COND_WIDTH  = 2,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   clear,
   input  logic [DATA_WIDTH-1:0]  bus_Data,
   input  logic [IR_WIDTH-1:0]    instruction,
   input  logic                   con_enable,
   input  logic                   con_ack,
   input  logic                   stats_clear,
   output logic                   con_output,
   output logic                   con_valid,
   output logic                   con_busy,
   output logic [COUNT_WIDTH-1:0] eval_count,
   output logic [COUNT_WIDTH-1:0] taken_count
);

   typedef enum logic [1:0] {S_IDLE, S_CAPT, S_EVAL, S_HOLD} state_t;

   localparam logic [IR_WIDTH-1:0] CC_MASK =
      ((IR_WIDTH'(1) << COND_WIDTH) - IR_WIDTH'(1)) << COND_LSB;

   state_t                  state_q, state_d;
   logic [COND_WIDTH-1:0]   cc_q, cc_d;
   logic [DATA_WIDTH-1:0]   val_q, val_d;
   logic                    out_q, out_d;
   logic                    valid_q, valid_d;
   logic                    busy_q, busy_d;
   logic [COUNT_WIDTH-1:0]  eval_cnt_q, eval_cnt_d;
   logic [COUNT_WIDTH-1:0]  taken_cnt_q, taken_cnt_d;

   logic                    capture;
   logic                    evaluating;
   logic                    result;
   logic [2:0]              cc_ext;
   logic                    unused_ir;

   // Only the condition field of the instruction matters here.
   assign unused_ir = ^(instruction & ~CC_MASK);
   assign cc_ext    = 3'(cc_q);

   function automatic logic eval_cond(input logic [2:0] cc, input logic [DATA_WIDTH-1:0] v);
      logic z, n;
      z = (v == '0);
      n = v[DATA_WIDTH-1];
      case (cc)
         3'd0:    eval_cond = z;
         3'd1:    eval_cond = !z;
         3'd2:    eval_cond = !n;
         3'd3:    eval_cond = n;
         3'd4:    eval_cond = 1'b1;
         3'd5:    eval_cond = 1'b0;
         3'd6:    eval_cond = !n && !z;
         default: eval_cond = n || z;
      endcase
   endfunction

   function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
      sat_inc = (&c) ? c : c + COUNT_WIDTH'(1);
   endfunction

   // State register
   always_ff @(posedge clock) begin
      if (clear) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (con_enable) state_d = S_CAPT;
         S_CAPT: state_d = S_EVAL;
         S_EVAL: state_d = S_HOLD;
         S_HOLD: if (con_ack) state_d = con_enable ? S_CAPT : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output and datapath next-state logic
   always_comb begin
      capture     = ((state_q == S_IDLE) || ((state_q == S_HOLD) && con_ack)) && con_enable;
      evaluating  = (state_q == S_EVAL);
      result      = eval_cond(cc_ext, val_q);
      cc_d        = capture ? instruction[COND_LSB +: COND_WIDTH] : cc_q;
      val_d       = capture ? bus_Data : val_q;
      out_d       = evaluating ? result : out_q;
      busy_d      = (state_d == S_CAPT) || (state_d == S_EVAL);
      valid_d     = valid_q;
      if (evaluating)                         valid_d = 1'b1;
      else if ((state_q == S_HOLD) && con_ack) valid_d = 1'b0;
      eval_cnt_d  = eval_cnt_q;
      taken_cnt_d = taken_cnt_q;
      if (stats_clear) begin
         eval_cnt_d  = '0;
         taken_cnt_d = '0;
      end else if (evaluating) begin
         eval_cnt_d = sat_inc(eval_cnt_q);
         if (result) taken_cnt_d = sat_inc(taken_cnt_q);
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         cc_q        <= '0;
         val_q       <= '0;
         out_q       <= 1'b0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         eval_cnt_q  <= '0;
         taken_cnt_q <= '0;
      end else begin
         cc_q        <= cc_d;
         val_q       <= val_d;
         out_q       <= out_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         eval_cnt_q  <= eval_cnt_d;
         taken_cnt_q <= taken_cnt_d;
      end
   end

   assign con_output  = out_q;
   assign con_valid   = valid_q;
   assign con_busy    = busy_q;
   assign eval_count  = eval_cnt_q;
   assign taken_count = taken_cnt_q;

endmodule

// File: tb/tb_con_unit.sv
// Directed bench for con_unit: a 2-bit-condition instance and a 3-bit-condition,
// 4-bit-counter instance driven from the same stimulus.
module tb_con_unit;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] bus_Data = '0;
   logic [31:0] instruction = '0;
   logic        con_enable = 1'b0;
   logic        con_ack = 1'b0;
   logic        stats_clear = 1'b0;

   logic        out2, valid2, busy2;
   logic [15:0] ev2_o, tk2_o;
   logic        out3, valid3, busy3;
   logic [3:0]  ev3_o, tk3_o;

   int vectors = 0;
   int miscompares = 0;
   int ev2 = 0, tk2 = 0, ev3 = 0, tk3 = 0;

   always #5 clock = ~clock;

   con_unit #(.DATA_WIDTH(32), .IR_WIDTH(32), .COND_LSB(19), .COND_WIDTH(2), .COUNT_WIDTH(16)) dut2 (
      .clock(clock), .clear(clear), .bus_Data(bus_Data), .instruction(instruction),
      .con_enable(con_enable), .con_ack(con_ack), .stats_clear(stats_clear),
      .con_output(out2), .con_valid(valid2), .con_busy(busy2),
      .eval_count(ev2_o), .taken_count(tk2_o)
   );

   con_unit #(.DATA_WIDTH(32), .IR_WIDTH(32), .COND_LSB(19), .COND_WIDTH(3), .COUNT_WIDTH(4)) dut3 (
      .clock(clock), .clear(clear), .bus_Data(bus_Data), .instruction(instruction),
      .con_enable(con_enable), .con_ack(con_ack), .stats_clear(stats_clear),
      .con_output(out3), .con_valid(valid3), .con_busy(busy3),
      .eval_count(ev3_o), .taken_count(tk3_o)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, " eval2"}, 32'(ev2_o), ev2);
      chk({tag, " taken2"}, 32'(tk2_o), tk2);
      chk({tag, " eval3"}, 32'(ev3_o), ev3);
      chk({tag, " taken3"}, 32'(tk3_o), tk3);
   endtask

   task automatic model_eval(input logic e2, input logic e3);
      ev2++;
      if (e2) tk2++;
      if (ev3 < 15) ev3++;
      if (e3 && tk3 < 15) tk3++;
   endtask

   task automatic model_zero();
      ev2 = 0; tk2 = 0; ev3 = 0; tk3 = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " out2"}, 32'(out2), 0);
      chk({tag, " out3"}, 32'(out3), 0);
      chk({tag, " valid2"}, 32'(valid2), 0);
      chk({tag, " valid3"}, 32'(valid3), 0);
      chk({tag, " busy2"}, 32'(busy2), 0);
      chk({tag, " busy3"}, 32'(busy3), 0);
      chk_counts(tag);
   endtask

   // Strobe one evaluation and check the decision two edges later; leaves the unit in HOLD.
   task automatic do_eval(input string tag, input logic [2:0] cc, input logic [31:0] bus,
                          input logic e2, input logic e3, input bit scramble);
      instruction = 32'(cc) << 19;
      bus_Data    = bus;
      con_enable  = 1'b1;
      tick();
      con_enable  = 1'b0;
      chk({tag, " busy2"}, 32'(busy2), 1);
      chk({tag, " busy3"}, 32'(busy3), 1);
      chk({tag, " valid3 low"}, 32'(valid3), 0);
      if (scramble) begin
         bus_Data    = 32'h0;
         instruction = 32'h0;
      end
      tick();
      tick();
      model_eval(e2, e3);
      chk({tag, " valid2"}, 32'(valid2), 1);
      chk({tag, " valid3"}, 32'(valid3), 1);
      chk({tag, " out2"}, 32'(out2), 32'(e2));
      chk({tag, " out3"}, 32'(out3), 32'(e3));
      chk({tag, " busy3 hold"}, 32'(busy3), 0);
      chk_counts(tag);
   endtask

   task automatic do_ack(input string tag, input logic e2, input logic e3);
      con_ack = 1'b1;
      tick();
      con_ack = 1'b0;
      chk({tag, " ack valid2"}, 32'(valid2), 0);
      chk({tag, " ack valid3"}, 32'(valid3), 0);
      chk({tag, " ack out2"}, 32'(out2), 32'(e2));
      chk({tag, " ack out3"}, 32'(out3), 32'(e3));
   endtask

   initial begin
      // Reset
      clear = 1'b1;
      tick();
      tick();
      clear = 1'b0;
      chk_zero("reset");

      // Codes 0-3 on both instances; scramble live inputs during CAPT
      do_eval("cc0 zero", 3'd0, 32'h0000_0000, 1, 1, 0);
      do_ack("cc0 zero", 1, 1);
      do_eval("cc3 neg", 3'd3, 32'h8000_0000, 1, 1, 0);
      do_ack("cc3 neg", 1, 1);
      do_eval("cc2 neg", 3'd2, 32'h8000_0000, 0, 0, 0);
      do_ack("cc2 neg", 0, 0);
      do_eval("cc1 five", 3'd1, 32'h0000_0005, 1, 1, 1);
      do_ack("cc1 five", 1, 1);

      // Clear statistics while idle
      stats_clear = 1'b1;
      tick();
      stats_clear = 1'b0;
      model_zero();
      chk_counts("stats idle");

      // Codes 4-7: the 2-bit instance sees only the low two bits
      do_eval("cc6 zero", 3'd6, 32'h0000_0000, 1, 0, 0);
      do_ack("cc6 zero", 1, 0);
      do_eval("cc7 zero", 3'd7, 32'h0000_0000, 0, 1, 0);
      do_ack("cc7 zero", 0, 1);
      do_eval("cc4 always", 3'd4, 32'h8000_0000, 0, 1, 0);
      do_ack("cc4 always", 0, 1);
      do_eval("cc5 never", 3'd5, 32'h0000_0000, 0, 0, 0);
      do_ack("cc5 never", 0, 0);
      chk("after4 eval3", 32'(ev3_o), 4);
      chk("after4 taken3", 32'(tk3_o), 2);

      // Stall in HOLD while enable pulses without ack
      do_eval("stall", 3'd4, 32'h0000_0000, 1, 1, 0);
      instruction = 32'(3'd5) << 19;
      for (int i = 0; i < 5; i++) begin
         con_enable = (i % 2 == 0);
         tick();
         chk("stall valid3", 32'(valid3), 1);
         chk("stall out3", 32'(out3), 1);
         chk("stall busy3", 32'(busy3), 0);
         chk_counts("stall");
      end

      // Ack and enable together: new decision two edges later
      bus_Data   = 32'h0;
      con_enable = 1'b1;
      con_ack    = 1'b1;
      tick();
      con_enable = 1'b0;
      con_ack    = 1'b0;
      chk("b2b valid3", 32'(valid3), 0);
      chk("b2b busy3", 32'(busy3), 1);
      tick();
      tick();
      model_eval(0, 0);
      chk("b2b valid3 new", 32'(valid3), 1);
      chk("b2b out3", 32'(out3), 0);
      chk("b2b out2", 32'(out2), 0);
      chk_counts("b2b");
      do_ack("b2b", 0, 0);

      // Drive the 4-bit counters into saturation
      for (int i = 0; i < 20; i++) begin
         do_eval("sat", 3'd4, 32'h0000_0000, 1, 1, 0);
         do_ack("sat", 1, 1);
      end
      chk("sat eval3", 32'(ev3_o), 32'hF);
      chk("sat taken3", 32'(tk3_o), 32'hF);

      // stats_clear coinciding with EVAL exit
      instruction = 32'(3'd4) << 19;
      bus_Data    = 32'h0;
      con_enable  = 1'b1;
      tick();
      con_enable  = 1'b0;
      tick();
      stats_clear = 1'b1;
      tick();
      stats_clear = 1'b0;
      model_zero();
      chk("sclr valid3", 32'(valid3), 1);
      chk("sclr out3", 32'(out3), 1);
      chk_counts("sclr");
      do_ack("sclr", 1, 1);

      // Reset during EVAL
      instruction = 32'(3'd4) << 19;
      con_enable  = 1'b1;
      tick();
      con_enable  = 1'b0;
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_zero();
      chk_zero("rst eval");
      do_eval("post rst eval", 3'd3, 32'h8000_0000, 1, 1, 0);

      // Reset during HOLD discards the pending decision
      do_ack("post rst eval", 1, 1);
      do_eval("pre rst hold", 3'd1, 32'h0000_0007, 1, 1, 0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_zero();
      chk_zero("rst hold");
      do_eval("post rst hold", 3'd0, 32'h0000_0000, 1, 1, 0);
      do_ack("post rst hold", 1, 1);

      // Ack while idle has no effect; decision value persists
      con_ack = 1'b1;
      tick();
      con_ack = 1'b0;
      chk("idle ack valid3", 32'(valid3), 0);
      chk("idle ack out3", 32'(out3), 1);
      chk("idle ack busy3", 32'(busy3), 0);
      chk_counts("idle ack");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/con_unit.md
# con_unit

Parametrised branch-condition unit for the datapath. It replaces the single combinational CON flip-flop with a registered, handshaked evaluator. The unit captures the condition field of the instruction register and the bus value when the control unit strobes `con_enable`, evaluates one of up to eight conditions, and holds a valid branch decision until the control unit acknowledges it. Saturating statistics counters for evaluations and taken branches are kept for the performance-monitor path.

## Interface
- `DATA_WIDTH`, 32, width of `bus_Data` and of the compared value
- `IR_WIDTH`, 32, width of `instruction`
- `COND_LSB`, 19, bit position of the LSB of the condition field in `instruction`
- `COND_WIDTH`, 2, condition field width; legal values 2 or 3
- `COUNT_WIDTH`, 16, width of each statistics counter
- `clock  input  1  system clock; all state updates on rising edge`
- `clear  input  1  reset; one clock; reset is synchronous and active-high`
- `bus_Data  input  DATA_WIDTH  value under test, two's complement`
- `instruction  input  IR_WIDTH  instruction register contents`
- `con_enable  input  1  capture strobe from control unit`
- `con_ack  input  1  control unit has consumed the decision`
- `stats_clear  input  1  synchronous zero of both counters`
- `con_output  output  1  registered branch decision (1 = take)`
- `con_valid  output  1  con_output holds a fresh, unacknowledged decision`
- `con_busy  output  1  high in CAPT or EVAL state`
- `eval_count  output  COUNT_WIDTH  number of completed evaluations, saturating`
- `taken_count  output  COUNT_WIDTH  number of evaluations with result 1, saturating`

## Operation
- Condition code `cc = instruction[COND_LSB +: COND_WIDTH]`. With COND_WIDTH=2, only codes 0-3 exist.
- Condition codes:
  - 0: value == 0
  - 1: value != 0
  - 2: value non-negative (MSB == 0)
  - 3: value negative (MSB == 1)
  - 4: always
  - 5: never
  - 6: value > 0 signed (MSB == 0 and value != 0)
  - 7: value <= 0 signed (MSB == 1 or value == 0)
- Comparisons use the captured copies only. Changes on `bus_Data` or `instruction` after capture have no effect.
- FSM states:
  - IDLE: `con_enable` high → latch cc and bus value → CAPT.
  - CAPT: unconditional → EVAL.
  - EVAL: register the result into `con_output`, set `con_valid`, increment `eval_count` and (if result is 1) `taken_count` → HOLD.
  - HOLD: `con_ack` high → clear `con_valid` → IDLE. If `con_enable` is also high in the same cycle, latch the new operands and go to CAPT instead.
- `con_enable` is ignored in CAPT and EVAL. It is also ignored in HOLD without `con_ack`, with no capture and no error flag.
- `con_output` keeps its last value in IDLE and after ack. It changes only on EVAL exit or reset.
- Counters:
  - Saturate at all-ones and never wrap.
  - `stats_clear` zeroes both counters. If it coincides with an EVAL exit, the clear wins and the counters read 0 next cycle.

## Timing
- Reset (`clear` high at an edge): state IDLE; `con_output`=0, `con_valid`=0, `con_busy`=0, `eval_count`=0, `taken_count`=0, captured registers = 0.
- Reset dominates all other inputs and aborts any evaluation in flight, including one in HOLD; the pending decision is discarded.
- Latency from strobe to decision:
  - `con_enable` is sampled high in IDLE at edge k.
  - `con_busy` is high after edge k.
  - `con_output` and `con_valid` update after edge k+2.
  - Counters update after edge k+2.
- Handshake: `con_valid` stays high from edge k+2 until the edge at which `con_ack` is sampled high, and drops after that edge. Ack sampled while `con_valid` is low has no effect.
- Back-to-back operation: with ack and enable asserted together in HOLD, the next decision is valid 2 edges later. Sustained throughput is one decision per 3 cycles.
- `con_busy` is a registered output, high exactly in CAPT and EVAL.

## Test plan
- Reset, then cc=0 and bus=0x00000000 with a one-cycle `con_enable` → `con_valid`=1 and `con_output`=1 two edges later; `eval_count`=1, `taken_count`=1.
- cc=3, bus=0x80000000 → 1. cc=2, same bus → 0. cc=1, bus=0x00000005 → 1 (all with COND_WIDTH=2). Drive `bus_Data` to 0 during CAPT → result is unchanged.
- COND_WIDTH=3: cc=6 with bus=0 → 0; cc=7 with bus=0 → 1; cc=4 → 1; cc=5 → 0. After these four, `eval_count`=4 and `taken_count`=2.
- Hold `con_ack` low for 5 cycles in HOLD while pulsing `con_enable` → `con_valid` stays 1, `con_output` is stable and counters are unchanged. Then ack and enable together → new decision valid 2 edges later.
- COUNT_WIDTH=4, 20 taken evaluations → both counters read 0xF. Then `stats_clear` coincident with an EVAL exit → both counters read 0.
- Assert `clear` in EVAL and again in HOLD → all outputs 0 next cycle, FSM in IDLE, and a fresh strobe is accepted one cycle later.
